// File: rtl/ttl_74155_seq_pkg.sv
// Shared constants for the 74155-style strobed 2-to-4 decoder array.
package ttl_74155_seq_pkg;

    localparam int MODE_LEVEL     = 0;
    localparam int MODE_PULSE     = 1;
    localparam int RETRIG_IGNORE  = 0;
    localparam int RETRIG_RESTART = 1;

    // Counter must hold the value PULSE_LEN itself, hence the +1.
    function automatic int cnt_width(input int pulse_len);
        return $clog2(pulse_len + 1);
    endfunction

endpackage

// File: rtl/ttl_74155_seq_strobe_channel.sv
// One decoder channel: enable edge detect, address latch, strobe counter and
// registered active-low one-hot decode.
module ttl_strobe_channel
    import ttl_74155_seq_pkg::*;
#(
    parameter int WIDTH_OUT  = 4,
    parameter int WIDTH_IN   = 2,
    parameter int PULSE_MODE = MODE_PULSE,
    parameter int PULSE_LEN  = 2,
    parameter int RETRIGGER  = RETRIG_IGNORE
) (
    input  logic                 clk,
    input  logic                 reset_bar,
    input  logic                 enable_c,
    input  logic                 enable_g_bar,
    input  logic [WIDTH_IN-1:0]  a,
    output logic [WIDTH_OUT-1:0] y,
    output logic                 busy
);

    localparam int               CNT_W = cnt_width(PULSE_LEN);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(PULSE_LEN);

    logic                 en;
    logic                 trigger;
    logic                 accept;
    logic                 active;
    logic [WIDTH_IN-1:0]  sel;
    logic                 en_prev_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;
    logic [WIDTH_IN-1:0]  addr_reg;
    logic [WIDTH_IN-1:0]  addr_next;
    logic [WIDTH_OUT-1:0] y_reg;
    logic [WIDTH_OUT-1:0] y_next;
    logic                 busy_reg;

    assign en      = enable_c & ~enable_g_bar;
    assign trigger = en & ~en_prev_reg;

    always_comb begin
        // A counter at 1 expires on this edge, so a trigger here abuts the old strobe.
        accept    = trigger && (RETRIGGER != 0 || cnt_reg <= CNT_W'(1));
        cnt_next  = cnt_reg;
        addr_next = addr_reg;
        active    = 1'b0;
        sel       = '0;
        if (accept) begin
            cnt_next  = LOAD;
            addr_next = a;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
        if (PULSE_MODE == MODE_PULSE) begin
            active = (cnt_next != '0);
            sel    = addr_next;
        end else begin
            active = en;
            sel    = a;
        end
    end

    // Addresses beyond WIDTH_OUT match no bit and so leave every output high.
    generate
        for (genvar gi = 0; gi < WIDTH_OUT; gi++) begin : g_dec
            assign y_next[gi] = ~(active && (sel == WIDTH_IN'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            en_prev_reg <= 1'b0;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            y_reg       <= '1;
            busy_reg    <= 1'b0;
        end else begin
            en_prev_reg <= en;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            y_reg       <= y_next;
            busy_reg    <= active;
        end
    end

    assign y    = y_reg;
    assign busy = busy_reg;

endmodule

// File: rtl/ttl_74155_seq.sv
// Array of independent strobed decoder channels with packed address/output buses.
module ttl_74155_seq
    import ttl_74155_seq_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WIDTH_OUT  = 4,
    parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
    parameter int PULSE_MODE = MODE_PULSE,
    parameter int PULSE_LEN  = 2,
    parameter int RETRIGGER  = RETRIG_IGNORE
) (
    input  logic                          Clk,
    input  logic                          Reset_bar,
    input  logic [CHANNELS-1:0]           Enable_C,
    input  logic [CHANNELS-1:0]           Enable_G_bar,
    input  logic [CHANNELS*WIDTH_IN-1:0]  A,
    output logic [CHANNELS*WIDTH_OUT-1:0] Y_2D,
    output logic [CHANNELS-1:0]           Busy
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            ttl_strobe_channel #(
                .WIDTH_OUT  (WIDTH_OUT),
                .WIDTH_IN   (WIDTH_IN),
                .PULSE_MODE (PULSE_MODE),
                .PULSE_LEN  (PULSE_LEN),
                .RETRIGGER  (RETRIGGER)
            ) u_chan (
                .clk          (Clk),
                .reset_bar    (Reset_bar),
                .enable_c     (Enable_C[gi]),
                .enable_g_bar (Enable_G_bar[gi]),
                .a            (A[gi*WIDTH_IN +: WIDTH_IN]),
                .y            (Y_2D[gi*WIDTH_OUT +: WIDTH_OUT]),
                .busy         (Busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ttl_74155_seq.sv
// Four differently configured decoders share one stimulus stream and are checked
// every cycle against a strobe-window reference model.
module tb_ttl_74155_seq;

    logic       clk;
    logic       rst_bar;
    logic [1:0] en_c;
    logic [1:0] en_g_bar;
    logic [3:0] a_in;

    logic [7:0] y_a, y_b, y_d;
    logic [5:0] y_c;
    logic [1:0] busy_a, busy_b, busy_c, busy_d;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Configurations: 0 = defaults, 1 = len3 restart, 2 = 3 outputs len3 ignore, 3 = level.
    int cfg_pm[4] = '{1, 1, 1, 0};
    int cfg_pl[4] = '{2, 3, 3, 2};
    int cfg_rt[4] = '{0, 1, 0, 0};
    int cfg_wo[4] = '{4, 4, 3, 4};

    // Strobe model: output active after edge n while n < m_end.
    int m_end[4][2];
    int m_addr[4][2];
    bit m_prev[4][2];
    bit m_act[4][2];
    int m_sel[4][2];

    ttl_74155_seq #(.CHANNELS(2), .WIDTH_OUT(4), .PULSE_MODE(1), .PULSE_LEN(2), .RETRIGGER(0)) dut_a (
        .Clk(clk), .Reset_bar(rst_bar), .Enable_C(en_c), .Enable_G_bar(en_g_bar),
        .A(a_in), .Y_2D(y_a), .Busy(busy_a));
    ttl_74155_seq #(.CHANNELS(2), .WIDTH_OUT(4), .PULSE_MODE(1), .PULSE_LEN(3), .RETRIGGER(1)) dut_b (
        .Clk(clk), .Reset_bar(rst_bar), .Enable_C(en_c), .Enable_G_bar(en_g_bar),
        .A(a_in), .Y_2D(y_b), .Busy(busy_b));
    ttl_74155_seq #(.CHANNELS(2), .WIDTH_OUT(3), .PULSE_MODE(1), .PULSE_LEN(3), .RETRIGGER(0)) dut_c (
        .Clk(clk), .Reset_bar(rst_bar), .Enable_C(en_c), .Enable_G_bar(en_g_bar),
        .A(a_in), .Y_2D(y_c), .Busy(busy_c));
    ttl_74155_seq #(.CHANNELS(2), .WIDTH_OUT(4), .PULSE_MODE(0), .PULSE_LEN(2), .RETRIGGER(0)) dut_d (
        .Clk(clk), .Reset_bar(rst_bar), .Enable_C(en_c), .Enable_G_bar(en_g_bar),
        .A(a_in), .Y_2D(y_d), .Busy(busy_d));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                bit en;
                int av;
                en = en_c[ch] && !en_g_bar[ch];
                av = int'(a_in[ch*2 +: 2]);
                if (!rst_bar) begin
                    m_end[c][ch]  = 0;
                    m_addr[c][ch] = 0;
                    m_prev[c][ch] = 1'b0;
                    m_act[c][ch]  = 1'b0;
                    m_sel[c][ch]  = 0;
                end else if (cfg_pm[c] == 0) begin
                    m_prev[c][ch] = en;
                    m_act[c][ch]  = en;
                    m_sel[c][ch]  = av;
                end else begin
                    // A rising enable starts a strobe unless one continues past this edge.
                    if (en && !m_prev[c][ch] && (cfg_rt[c] != 0 || cyc >= m_end[c][ch])) begin
                        m_end[c][ch]  = cyc + cfg_pl[c];
                        m_addr[c][ch] = av;
                    end
                    m_prev[c][ch] = en;
                    m_act[c][ch]  = (cyc < m_end[c][ch]);
                    m_sel[c][ch]  = m_addr[c][ch];
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_y(input int c);
        logic [31:0] v;
        v = '0;
        for (int ch = 0; ch < 2; ch++)
            for (int b = 0; b < cfg_wo[c]; b++)
                if (!(m_act[c][ch] && m_sel[c][ch] == b))
                    v[ch*cfg_wo[c] + b] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] exp_busy(input int c);
        logic [31:0] v;
        v = '0;
        v[0] = m_act[c][0];
        v[1] = m_act[c][1];
        return v;
    endfunction

    task automatic compare_all();
        logic [31:0] oy, ob;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       begin oy = 32'(y_a); ob = 32'(busy_a); end
                1:       begin oy = 32'(y_b); ob = 32'(busy_b); end
                2:       begin oy = 32'(y_c); ob = 32'(busy_c); end
                default: begin oy = 32'(y_d); ob = 32'(busy_d); end
            endcase
            check_eq($sformatf("cyc%0d cfg%0d y", cyc, c), oy, exp_y(c));
            check_eq($sformatf("cyc%0d cfg%0d busy", cyc, c), ob, exp_busy(c));
        end
    endtask

    task automatic apply_step(input logic r, input logic [1:0] ec, input logic [1:0] gb,
                              input logic [3:0] a);
        rst_bar  = r;
        en_c     = ec;
        en_g_bar = gb;
        a_in     = a;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
        $display("cyc=%0d rst_bar=%b en_c=%b en_g_bar=%b a=%h | ya=%h/%b yb=%h/%b yc=%h/%b yd=%h/%b",
                 cyc, r, ec, gb, a, y_a, busy_a, y_b, busy_b, y_c, busy_c, y_d, busy_d);
    endtask

    initial begin
        rst_bar  = 1'b0;
        en_c     = '0;
        en_g_bar = '0;
        a_in     = '0;

        apply_step(1'b0, 2'b00, 2'b00, 4'h0);
        apply_step(1'b0, 2'b00, 2'b00, 4'h0);
        check_eq("reset.y", 32'(y_a), 32'h000000ff);
        check_eq("reset.busy", 32'(busy_a), 32'h0);
        apply_step(1'b1, 2'b00, 2'b00, 4'h0);

        // Single strobe on ch0 address 2, then address change and enable drop mid-strobe.
        apply_step(1'b1, 2'b01, 2'b00, 4'h2);
        check_eq("strobe.first", 32'(y_a[3:0]), 32'hb);
        check_eq("strobe.busy", 32'(busy_a), 32'h1);
        apply_step(1'b1, 2'b00, 2'b00, 4'h1);
        check_eq("strobe.held", 32'(y_a[3:0]), 32'hb);
        apply_step(1'b1, 2'b00, 2'b00, 4'h1);
        check_eq("strobe.end", 32'(y_a[3:0]), 32'hf);
        check_eq("strobe.idle", 32'(busy_a), 32'h0);
        apply_step(1'b1, 2'b00, 2'b00, 4'h0);

        // Retrigger with a new address two edges into a length-3 strobe.
        apply_step(1'b1, 2'b01, 2'b00, 4'h2);
        apply_step(1'b1, 2'b00, 2'b00, 4'h2);
        apply_step(1'b1, 2'b01, 2'b00, 4'h0);
        check_eq("retrig.restart", 32'(y_b[3:0]), 32'he);
        check_eq("retrig.ignore", 32'(y_c[2:0]), 32'h3);
        apply_step(1'b1, 2'b01, 2'b00, 4'h0);
        check_eq("retrig.ignore_end", 32'(y_c[2:0]), 32'h7);
        check_eq("retrig.busy_cont", 32'(busy_b[0]), 32'h1);
        apply_step(1'b1, 2'b01, 2'b00, 4'h0);
        apply_step(1'b1, 2'b01, 2'b00, 4'h0);
        check_eq("retrig.end", 32'(y_b[3:0]), 32'hf);
        apply_step(1'b1, 2'b00, 2'b00, 4'h0);

        // Out-of-range address on the 3-output decoder.
        apply_step(1'b1, 2'b01, 2'b00, 4'h3);
        check_eq("oor.y", 32'(y_c[2:0]), 32'h7);
        check_eq("oor.busy", 32'(busy_c[0]), 32'h1);
        apply_step(1'b1, 2'b00, 2'b00, 4'h3);
        apply_step(1'b1, 2'b00, 2'b00, 4'h3);
        check_eq("oor.busy_last", 32'(busy_c[0]), 32'h1);
        apply_step(1'b1, 2'b00, 2'b00, 4'h3);
        check_eq("oor.busy_end", 32'(busy_c[0]), 32'h0);

        // Reset mid-strobe on both channels with enables held through release.
        apply_step(1'b1, 2'b11, 2'b00, 4'h6);
        apply_step(1'b0, 2'b11, 2'b00, 4'h6);
        check_eq("abort.y", 32'(y_a), 32'h000000ff);
        check_eq("abort.busy", 32'(busy_a), 32'h0);
        apply_step(1'b1, 2'b11, 2'b00, 4'h6);
        check_eq("abort.retrig", 32'(y_a), 32'h000000db);
        check_eq("abort.retrig_busy", 32'(busy_a), 32'h3);

        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [1:0] ec, gb;
            r     = ($urandom_range(0, 39) != 0);
            ec    = 2'($urandom_range(0, 3));
            gb[0] = ($urandom_range(0, 3) == 0);
            gb[1] = ($urandom_range(0, 3) == 0);
            apply_step(r, ec, gb, 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ttl_74155_seq.md
TTL_74155_SEQ -- requirements
Module: ttl_74155_seq

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent decoder channels.
REQ-002 SHALL have parameter WIDTH_OUT, default 4: outputs per channel, range 2..16.
REQ-003 SHALL have parameter WIDTH_IN, default $clog2(WIDTH_OUT): address bits per channel.
REQ-004 SHALL have parameter PULSE_MODE, default 1: 1 = one-shot strobe, 0 = registered level decode.
REQ-005 SHALL have parameter PULSE_LEN, default 2: strobe width in Clk cycles, range 1..255.
REQ-006 SHALL have parameter RETRIGGER, default 0: 1 = new trigger restarts an active strobe, 0 = new trigger ignored while busy.
REQ-007 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-008 SHALL have port Reset_bar, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port Enable_C, input, CHANNELS: per-channel enable, active-high.
REQ-010 SHALL have port Enable_G_bar, input, CHANNELS: per-channel enable, active-low.
REQ-011 SHALL have port A, input, CHANNELS*WIDTH_IN: packed addresses; channel k at bits [k*WIDTH_IN +: WIDTH_IN].
REQ-012 SHALL have port Y_2D, output, CHANNELS*WIDTH_OUT: packed active-low outputs; channel k at bits [k*WIDTH_OUT +: WIDTH_OUT].
REQ-013 SHALL have port Busy, output, CHANNELS: channel k is driving an active output.

Function
REQ-014 Channel k SHALL be enabled when Enable_C[k]=1 and Enable_G_bar[k]=0.
REQ-015 Every Y_2D bit SHALL be driven from a flop; there is no combinational path from any input to Y_2D or Busy.
REQ-016 In level mode (PULSE_MODE=0), channel k SHALL drive exactly one output low, bit A_k, one cycle after the sampling edge while enabled. All of its bits SHALL be high otherwise.
REQ-017 In pulse mode, a trigger SHALL be a sampled 0->1 transition of channel k's enable; a held-high enable SHALL NOT re-trigger.
REQ-018 On a trigger, the channel SHALL latch A_k and load its counter with PULSE_LEN; bit A_k SHALL go low on the next edge and stay low for exactly PULSE_LEN cycles.
REQ-019 The latched address SHALL be held for the whole strobe; changes to A during the strobe SHALL have no effect.
REQ-020 Enable deasserting mid-strobe SHALL NOT shorten the strobe.
REQ-021 With RETRIGGER=1, a trigger while busy SHALL latch the new address and reload PULSE_LEN, with no high gap when the address is unchanged.
REQ-022 With RETRIGGER=0, a trigger while busy SHALL be ignored; the edge detector SHALL still track the enable level.
REQ-023 A trigger on the same edge that the counter reaches 0 SHALL start a new strobe; the output SHALL stay low if the address is unchanged.
REQ-024 An address >= WIDTH_OUT (non-power-of-2 WIDTH_OUT) SHALL drive no output low; Busy SHALL still follow the counter.
REQ-025 Busy[k] SHALL be 1 exactly while channel k's counter is non-zero (pulse mode) or the channel is enabled (level mode), aligned with Y_2D.
REQ-026 Channels SHALL be fully independent; simultaneous triggers on all channels SHALL be legal.

Reset
REQ-027 When Reset_bar=0 at an edge, all Y_2D bits SHALL be set to 1, Busy to 0, counters and latched addresses to 0, and enable history to 0.
REQ-028 Reset SHALL abort a strobe in progress.
REQ-029 An enable already high when reset releases SHALL count as a trigger on the first edge after release.

Structure
REQ-030 Counter width ($clog2(PULSE_LEN+1)) and the mode encodings SHALL live in the shared ttl package.
REQ-031 One sub-module, ttl_strobe_channel (edge detect, address latch, counter, decode), SHALL be instantiated CHANNELS times via generate.

Verification
REQ-032 Reset, then enable ch0 with A=2, PULSE_LEN=2 -> Y_2D[3:0]=1011 for exactly 2 cycles, then 1111; Busy[0] matches.
REQ-033 During that strobe, change A to 1 and drop the enable -> output unchanged and the strobe length is still 2.
REQ-034 RETRIGGER=1, PULSE_LEN=3, re-trigger on cycle 2 with A=0 -> bit 2 released, bit 0 low 3 cycles, no overlap, Busy continuous.
REQ-035 RETRIGGER=0, same stimulus -> re-trigger ignored, single 3-cycle strobe on bit 2.
REQ-036 WIDTH_OUT=3, A=3 -> all outputs high, Busy high for PULSE_LEN cycles.
REQ-037 Assert Reset_bar=0 mid-strobe on both channels -> next edge Y_2D all ones, Busy=0; a held enable retriggers after release.
